dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Initiator-side controller for the 256-word data memory. It accepts word-addressed single or burst load/store requests from the pipeline over valid/ready handshakes and sequences them onto the memory's `addr`/`write_data`/`memwrite`/`memread`/`read_data` port. It returns read data with backpressure and one-beat-at-a-time write data acceptance. It sits between the MEM pipeline stage and the data memory.

## Interface
- `DEPTH`, 256: memory depth in words; addresses wrap modulo DEPTH (power of two).
- `RD_LAT`, 1: cycles `memread`+`addr` are held before `read_data` is sampled (≥1).
- `MAX_BURST`, 8: maximum beats per request.

Ports:
- `clk` in 1: the single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request; high only in IDLE.
- `req_write` in 1: 1 = store burst, 0 = load burst.
- `req_addr` in 32: base word address.
- `req_len` in 4: beat count; 0 treated as 1, values above MAX_BURST clamped to MAX_BURST.
- `wr_valid` in 1: store data beat present.
- `wr_ready` out 1: store beat accepted this cycle if `wr_valid`.
- `wr_data` in 32: store data.
- `rsp_valid` out 1: load data beat present.
- `rsp_ready` in 1: consumer takes the beat.
- `rsp_data` out 32: load data.
- `rsp_last` out 1: final beat of the burst, qualified by `rsp_valid`.
- `busy` out 1: high whenever state ≠ IDLE.
- `mem_addr` out 32: memory address; upper bits zero.
- `mem_write_data` out 32: memory write data.
- `mem_memwrite` out 1: write strobe.
- `mem_memread` out 1: read strobe.
- `mem_read_data` in 32: memory read data.

## Operation
- States: IDLE, WR_WAIT, WR_ISSUE, RD_ISSUE, RD_RESP.
- IDLE: `req_ready`=1. On `req_valid&&req_ready`, latch the base address, the clamped length and the direction, and clear the beat counter. Go to WR_WAIT if write, else RD_ISSUE.
- Beat address is `(base + beat) mod DEPTH`; wrap from DEPTH-1 to 0.
- WR_WAIT: `wr_ready`=1. On `wr_valid`, latch `wr_data` into `mem_write_data` and go to WR_ISSUE.
- WR_ISSUE: lasts one cycle with `mem_memwrite`=1 and `mem_addr` = beat address. Then increment the beat counter. Return to WR_WAIT if beats remain, else go to IDLE.
- RD_ISSUE: hold `mem_memread`=1 with `mem_addr` = beat address for RD_LAT cycles (internal counter). On the edge ending the last of these cycles, capture `mem_read_data` into `rsp_data`, set `rsp_last` if this is the final beat, and go to RD_RESP.
- RD_RESP: `rsp_valid`=1; `rsp_data` and `rsp_last` are stable until accepted. On `rsp_ready`, go to RD_ISSUE if beats remain, else go to IDLE.
- Strobes are never both high. Strobes are low in IDLE, WR_WAIT and RD_RESP, so there is at least one strobe-low cycle between consecutive memory accesses. `mem_addr` and `mem_write_data` hold their last value while strobes are low.
- `wr_valid` outside WR_WAIT is ignored; `rsp_ready` outside RD_RESP is ignored.

## Timing
- Reset: state IDLE. All outputs are 0 except `req_ready`=1; this includes `mem_addr`, `mem_write_data` and `rsp_data`. Counters are cleared.
- Reset mid-burst: the next cycle is IDLE with strobes low and `rsp_valid` low. The remaining beats are discarded, and there is no partial completion signalling.
- Write beat: a minimum of 2 cycles (WR_WAIT accept, WR_ISSUE strobe). The strobe occurs in the cycle after the `wr_valid&&wr_ready` edge.
- Read beat: request accepted at edge E0. `mem_memread` is high for cycles 1..RD_LAT after E0. `rsp_valid` rises the cycle after that. Minimum beat period is RD_LAT+1 cycles.
- `busy` rises the cycle after request acceptance. It falls the cycle after the final WR_ISSUE cycle or the final accepted response beat.
- A new request can be accepted in the first IDLE cycle after completion; there is no overlap between requests.

## Test plan
- Single store: req(write, addr=5, len=1), `wr_data`=0xDEADBEEF.
  - Expect exactly one cycle of `mem_memwrite`=1, `mem_addr`=5, `mem_write_data`=0xDEADBEEF.
  - Then `busy`=0 and `req_ready`=1.
- Single load with RD_LAT=1 and a memory model returning `addr`+100: req(read, addr=7, len=1).
  - Expect `mem_memread` high for 1 cycle at `mem_addr`=7.
  - Then `rsp_valid`=1 with `rsp_data`=107 and `rsp_last`=1.
- Wrapping burst: req(read, addr=254, len=4).
  - Expect `mem_addr` sequence 254, 255, 0, 1.
  - Expect `rsp_data` 354, 355, 100, 101, with `rsp_last` only on the 4th beat.
- Backpressure: same burst with `rsp_ready` low for 3 cycles on beat 2.
  - Expect `rsp_data`=355 held stable.
  - Expect no `mem_memread` until the beat is accepted.
- Store burst with gaps: len=3, `wr_valid` pulsed every 3rd cycle.
  - Expect three writes to consecutive addresses, each one cycle after its accepted beat.
  - Expect strobes low in between.
- Clamp and reset: req len=0 gives 1 beat; req len=15 gives 8 beats. Assert `rst` during beat 3 of the 8-beat read.
  - Expect strobes and `rsp_valid` low and `req_ready`=1 the next cycle.
  - Expect no further memory accesses.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data memory initiator: sequences single/burst word loads and stores
// from the MEM stage onto the data memory port.
module dmem_ctrl #(
  parameter int DEPTH     = 256,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  input  logic [31:0] mem_read_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    WR_ISSUE,
    RD_ISSUE,
    RD_RESP
  } state_t;

  state_t state, state_n;

  logic [AW-1:0] base;
  logic [AW-1:0] addr_q;
  logic [3:0]    len;
  logic [3:0]    beat;
  logic [LW-1:0] lat;
  logic [3:0]    len_c;
  logic [AW-1:0] beat_addr;
  logic          last;
  logic          lat_done;
  logic          unused_addr;

  assign unused_addr = ^req_addr[31:AW];

  always_comb begin
    len_c = req_len;
    if (req_len == 4'd0)
      len_c = 4'd1;
    else if (req_len > 4'(MAX_BURST))
      len_c = 4'(MAX_BURST);
  end

  assign beat_addr = base + AW'(beat);
  assign last      = (beat == len - 4'd1);
  assign lat_done  = (lat == LW'(RD_LAT - 1));

  assign req_ready    = (state == IDLE);
  assign wr_ready     = (state == WR_WAIT);
  assign rsp_valid    = (state == RD_RESP);
  assign busy         = (state != IDLE);
  assign mem_memwrite = (state == WR_ISSUE);
  assign mem_memread  = (state == RD_ISSUE);
  assign mem_addr     = {{(32-AW){1'b0}}, addr_q};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (req_valid)
          state_n = req_write ? WR_WAIT : RD_ISSUE;
      WR_WAIT:
        if (wr_valid) state_n = WR_ISSUE;
      WR_ISSUE:
        state_n = last ? IDLE : WR_WAIT;
      RD_ISSUE:
        if (lat_done) state_n = RD_RESP;
      RD_RESP:
        if (rsp_ready)
          state_n = last ? IDLE : RD_ISSUE;
      default:
        state_n = IDLE;
    endcase
  end

  // Address is loaded on entry to an issue state so it holds between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      base           <= '0;
      addr_q         <= '0;
      len            <= '0;
      beat           <= '0;
      lat            <= '0;
      mem_write_data <= '0;
      rsp_data       <= '0;
      rsp_last       <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (req_valid) begin
            base <= req_addr[AW-1:0];
            len  <= len_c;
            beat <= '0;
            lat  <= '0;
            if (!req_write) addr_q <= req_addr[AW-1:0];
          end
        WR_WAIT:
          if (wr_valid) begin
            mem_write_data <= wr_data;
            addr_q         <= beat_addr;
          end
        WR_ISSUE:
          beat <= beat + 4'd1;
        RD_ISSUE:
          if (lat_done) begin
            rsp_data <= mem_read_data;
            rsp_last <= last;
            lat      <= '0;
          end else begin
            lat <= lat + LW'(1);
          end
        RD_RESP:
          if (rsp_ready && !last) begin
            beat   <= beat + 4'd1;
            addr_q <= base + AW'(beat + 4'd1);
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed stimulus pushes expected memory
// accesses and responses; a negedge monitor pops and compares.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [31:0] rsp_data;
  logic        busy;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_memwrite, mem_memread;

  dmem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem_addr + 32'd100;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wr_acc_cyc = -10;
  int rsp_seen = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_memwrite && mem_memread)
        chk("both_strobes", 32'd1, 32'd0);
      if (mem_memwrite || mem_memread) begin
        if (acc_q.size() == 0) begin
          chk("unexpected_access", mem_addr, 32'hFFFF_FFFF);
        end else begin
          acc_t e;
          e = acc_q.pop_front();
          chk("acc_dir", {31'd0, mem_memwrite}, {31'd0, e.wr});
          chk("acc_addr", mem_addr, e.addr);
          if (e.wr) begin
            chk("wr_data", mem_write_data, e.data);
            chk("wr_lat", cyc, wr_acc_cyc + 1);
          end
        end
      end
      if (wr_valid && wr_ready) wr_acc_cyc = cyc;
      if (rsp_valid) begin
        if (mem_memread) chk("read_in_resp", 32'd1, 32'd0);
        if (hold_v) chk("rsp_stable", rsp_data, hold_d);
        if (rsp_ready) begin
          hold_v = 1'b0;
          rsp_seen++;
          if (rsp_q.size() == 0) begin
            chk("unexpected_rsp", rsp_data, 32'hFFFF_FFFF);
          end else begin
            rsp_t r;
            r = rsp_q.pop_front();
            chk("rsp_data", rsp_data, r.data);
            chk("rsp_last", {31'd0, rsp_last}, {31'd0, r.last});
          end
        end else begin
          hold_v = 1'b1;
          hold_d = rsp_data;
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic exp_acc(logic w, logic [31:0] a, logic [31:0] d);
    acc_t e;
    e.wr = w; e.addr = a; e.data = d;
    acc_q.push_back(e);
  endtask

  task automatic exp_rsp(logic [31:0] d, logic l);
    rsp_t r;
    r.data = d; r.last = l;
    rsp_q.push_back(r);
  endtask

  task automatic do_req(logic w, logic [31:0] a, logic [3:0] l);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 100);
    if (!req_ready) chk("req_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_beat(logic [31:0] d, int gap);
    int n;
    repeat (gap) @(posedge clk);
    #1;
    wr_valid = 1'b1; wr_data = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wr_ready && n < 100);
    if (!wr_ready) chk("wr_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({name, "_acc_left"}, acc_q.size(), 32'd0);
    chk({name, "_rsp_left"}, rsp_q.size(), 32'd0);
  endtask

  task automatic wait_rsp(int target);
    int n;
    n = 0;
    while (rsp_seen < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rsp_seen < target) chk("rsp_timeout", rsp_seen, target);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_outs", {26'd0, busy, rsp_valid, rsp_last, wr_ready,
                     mem_memwrite, mem_memread}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single store
    exp_acc(1'b1, 32'd5, 32'hDEADBEEF);
    do_req(1'b1, 32'd5, 4'd1);
    do_beat(32'hDEADBEEF, 0);
    wait_idle("store1");

    // single load
    exp_acc(1'b0, 32'd7, 32'd0);
    exp_rsp(32'd107, 1'b1);
    do_req(1'b0, 32'd7, 4'd1);
    wait_idle("load1");

    // wrapping read burst
    foreach (acc_q[i]) ;
    exp_acc(1'b0, 32'd254, 0); exp_acc(1'b0, 32'd255, 0);
    exp_acc(1'b0, 32'd0, 0);   exp_acc(1'b0, 32'd1, 0);
    exp_rsp(32'd354, 1'b0); exp_rsp(32'd355, 1'b0);
    exp_rsp(32'd100, 1'b0); exp_rsp(32'd101, 1'b1);
    do_req(1'b0, 32'd254, 4'd4);
    wait_idle("wrap");

    // same burst with backpressure on beat 2
    exp_acc(1'b0, 32'd254, 0); exp_acc(1'b0, 32'd255, 0);
    exp_acc(1'b0, 32'd0, 0);   exp_acc(1'b0, 32'd1, 0);
    exp_rsp(32'd354, 1'b0); exp_rsp(32'd355, 1'b0);
    exp_rsp(32'd100, 1'b0); exp_rsp(32'd101, 1'b1);
    begin
      int base_seen;
      int n;
      base_seen = rsp_seen;
      do_req(1'b0, 32'd254, 4'd4);
      wait_rsp(base_seen + 1);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rsp_valid && n < 50);
      repeat (3) begin
        chk("bp_data", rsp_data, 32'd355);
        chk("bp_no_read", {31'd0, mem_memread}, 32'd0);
        chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
      end
      rsp_ready = 1'b1;
    end
    wait_idle("bp");

    // store burst with gaps
    exp_acc(1'b1, 32'd40, 32'h1111_0001);
    exp_acc(1'b1, 32'd41, 32'h2222_0002);
    exp_acc(1'b1, 32'd42, 32'h3333_0003);
    do_req(1'b1, 32'd40, 4'd3);
    do_beat(32'h1111_0001, 2);
    do_beat(32'h2222_0002, 2);
    do_beat(32'h3333_0003, 2);
    wait_idle("wburst");

    // len 0 behaves as one beat
    exp_acc(1'b0, 32'd30, 0);
    exp_rsp(32'd130, 1'b1);
    do_req(1'b0, 32'd30, 4'd0);
    wait_idle("len0");

    // len 15 clamps to 8; reset during third beat
    exp_acc(1'b0, 32'd10, 0); exp_acc(1'b0, 32'd11, 0);
    exp_acc(1'b0, 32'd12, 0);
    exp_rsp(32'd110, 1'b0); exp_rsp(32'd111, 1'b0);
    begin
      int base_seen;
      int n;
      base_seen = rsp_seen;
      do_req(1'b0, 32'd10, 4'd15);
      wait_rsp(base_seen + 2);
      n = 0;
      while (!(mem_memread && mem_addr == 32'd12) && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("rst_mid_addr", mem_addr, 32'd12);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rstm_strobes", {30'd0, mem_memwrite, mem_memread}, 32'd0);
      chk("rstm_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rstm_req_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) @(negedge clk);
    end
    wait_idle("rstm");

    // clamp check: full 8-beat burst
    for (int i = 0; i < 8; i++) begin
      exp_acc(1'b0, 32'(60 + i), 0);
      exp_rsp(32'(160 + i), i == 7);
    end
    do_req(1'b0, 32'd60, 4'd15);
    wait_idle("len15");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
